// File: rtl/vga_rect_fill.sv
// rtl/vga_rect_fill.sv - rectangle fill engine driving the video buffer write port
// Optional outline mode: define VGA_RECT_OUTLINE_EN.
module vga_rect_fill #(
    parameter int COORD_W = 11,
    parameter int COLOR_W = 2,
    parameter int MAX_X   = 1280,
    parameter int MAX_Y   = 1024
) (
    input  logic               clk_i,
    input  logic               arstn_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [COORD_W-1:0] cmd_x0_i,
    input  logic [COORD_W-1:0] cmd_y0_i,
    input  logic [COORD_W-1:0] cmd_x1_i,
    input  logic [COORD_W-1:0] cmd_y1_i,
    input  logic [COLOR_W-1:0] cmd_color_i,
`ifdef VGA_RECT_OUTLINE_EN
    input  logic               cmd_outline_i,
`endif
    input  logic               pause_i,
    output logic [COLOR_W-1:0] color_o,
    output logic [COORD_W-1:0] addr_x_o,
    output logic [COORD_W-1:0] addr_y_o,
    output logic               we_o,
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(MAX_X - 1);
    localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(MAX_Y - 1);
    localparam logic [COORD_W:0]   X_LIMIT = (COORD_W + 1)'(MAX_X);
    localparam logic [COORD_W:0]   Y_LIMIT = (COORD_W + 1)'(MAX_Y);

    state_t             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [COORD_W-1:0] xl_q, xl_d;
    logic [COORD_W-1:0] xh_q, xh_d;
    logic [COORD_W-1:0] yh_q, yh_d;
    logic [COLOR_W-1:0] color_q, color_d;
`ifdef VGA_RECT_OUTLINE_EN
    logic [COORD_W-1:0] yl_q, yl_d;
    logic               outline_q, outline_d;
`endif

    logic [COORD_W-1:0] xl_n, xh_raw, xh_n;
    logic [COORD_W-1:0] yl_n, yh_raw, yh_n;
    logic               off_screen;
    logic               skip_interior;

    // Normalised, clipped bounds of the command currently on the inputs
    always_comb begin
        xl_n       = (cmd_x0_i < cmd_x1_i) ? cmd_x0_i : cmd_x1_i;
        xh_raw     = (cmd_x0_i < cmd_x1_i) ? cmd_x1_i : cmd_x0_i;
        yl_n       = (cmd_y0_i < cmd_y1_i) ? cmd_y0_i : cmd_y1_i;
        yh_raw     = (cmd_y0_i < cmd_y1_i) ? cmd_y1_i : cmd_y0_i;
        xh_n       = (xh_raw > X_LAST) ? X_LAST : xh_raw;
        yh_n       = (yh_raw > Y_LAST) ? Y_LAST : yh_raw;
        off_screen = ({1'b0, xl_n} >= X_LIMIT) || ({1'b0, yl_n} >= Y_LIMIT);
    end

`ifdef VGA_RECT_OUTLINE_EN
    assign skip_interior = outline_q && (y_q != yl_q) && (y_q != yh_q) && (x_q == xl_q);
`else
    assign skip_interior = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        xl_d    = xl_q;
        xh_d    = xh_q;
        yh_d    = yh_q;
        color_d = color_q;
`ifdef VGA_RECT_OUTLINE_EN
        yl_d      = yl_q;
        outline_d = outline_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    if (off_screen) begin
                        state_d = DONE;
                    end else begin
                        state_d = FILL;
                        x_d     = xl_n;
                        y_d     = yl_n;
                        xl_d    = xl_n;
                        xh_d    = xh_n;
                        yh_d    = yh_n;
                        color_d = cmd_color_i;
`ifdef VGA_RECT_OUTLINE_EN
                        yl_d      = yl_n;
                        outline_d = cmd_outline_i;
`endif
                    end
                end
            end
            FILL: begin
                // Compare against end values before incrementing so xh/yh at full scale never wrap
                if (!pause_i) begin
                    if (x_q == xh_q && y_q == yh_q) begin
                        state_d = DONE;
                    end else if (x_q == xh_q) begin
                        x_d = xl_q;
                        y_d = y_q + 1'b1;
                    end else if (skip_interior) begin
                        x_d = xh_q;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            xl_q    <= '0;
            xh_q    <= '0;
            yh_q    <= '0;
            color_q <= '0;
`ifdef VGA_RECT_OUTLINE_EN
            yl_q      <= '0;
            outline_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            xl_q    <= xl_d;
            xh_q    <= xh_d;
            yh_q    <= yh_d;
            color_q <= color_d;
`ifdef VGA_RECT_OUTLINE_EN
            yl_q      <= yl_d;
            outline_q <= outline_d;
`endif
        end
    end

    assign cmd_ready_o = (state_q == IDLE) && arstn_i;
    assign busy_o      = (state_q == FILL) || (state_q == DONE);
    assign done_o      = (state_q == DONE);
    assign we_o        = (state_q == FILL) && !pause_i;
    assign addr_x_o    = x_q;
    assign addr_y_o    = y_q;
    assign color_o     = color_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// tb/tb_vga_rect_fill.sv - directed self-checking bench for vga_rect_fill
`timescale 1ns/1ps
module tb_vga_rect_fill;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [10:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
    logic [1:0]  cmd_color = '0;
`ifdef VGA_RECT_OUTLINE_EN
    logic        cmd_outline = 1'b0;
`endif
    logic        pause = 1'b0;
    logic [1:0]  color;
    logic [10:0] addr_x, addr_y;
    logic        we, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    int wx[$];
    int wy[$];
    int wc[$];
    int wcyc[$];
    int done_cyc;

    always #5 clk = ~clk;

    vga_rect_fill dut (
        .clk_i        (clk),
        .arstn_i      (arstn),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_x0_i     (cmd_x0),
        .cmd_y0_i     (cmd_y0),
        .cmd_x1_i     (cmd_x1),
        .cmd_y1_i     (cmd_y1),
        .cmd_color_i  (cmd_color),
`ifdef VGA_RECT_OUTLINE_EN
        .cmd_outline_i(cmd_outline),
`endif
        .pause_i      (pause),
        .color_o      (color),
        .addr_x_o     (addr_x),
        .addr_y_o     (addr_y),
        .we_o         (we),
        .busy_o       (busy),
        .done_o       (done)
    );

    // Handshake then record writes; cycle 1 is the first cycle after the handshake edge.
    task automatic run_cmd(input int x0, input int y0, input int x1, input int y1, input int c,
                           input int p_first, input int p_last, input int budget);
        bit seen_done;
        wx.delete(); wy.delete(); wc.delete(); wcyc.delete();
        done_cyc  = -1;
        seen_done = 0;
        @(negedge clk);
        cmd_x0 = x0[10:0]; cmd_y0 = y0[10:0]; cmd_x1 = x1[10:0]; cmd_y1 = y1[10:0];
        cmd_color = c[1:0]; cmd_valid = 1'b1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake_ready: got %b want 1", cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_x0 = 11'd2047; cmd_x1 = 11'd2047;
        for (int k = 1; k <= budget && !seen_done; k++) begin
            pause = (k >= p_first && k <= p_last);
            @(negedge clk);
            if (we) begin
                wx.push_back(int'(addr_x)); wy.push_back(int'(addr_y));
                wc.push_back(int'(color));  wcyc.push_back(k);
            end
            if (done) begin
                done_cyc  = k;
                seen_done = 1;
                n_checks++;
                if (we !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_cycle_flags: we=%b busy=%b ready=%b want 0 1 0", we, busy, cmd_ready);
                end
            end else begin
                @(posedge clk);
                #1;
            end
        end
        pause = 1'b0;
        n_checks++;
        if (!seen_done) begin
            n_fail++;
            $display("FAIL done_timeout: no done_o within %0d cycles", budget);
        end
    endtask

    task automatic expect_writes(input string name, input int ex[$], input int ey[$],
                                 input int ecyc[$], input int ecol, input int edone);
        n_checks++;
        if (wx.size() != ex.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d writes want %0d", name, wx.size(), ex.size());
        end
        for (int i = 0; i < ex.size() && i < wx.size(); i++) begin
            n_checks++;
            if (wx[i] != ex[i] || wy[i] != ey[i] || wcyc[i] != ecyc[i] || wc[i] != ecol) begin
                n_fail++;
                $display("FAIL %s_write%0d: got (%0d,%0d) c=%0d cyc=%0d want (%0d,%0d) c=%0d cyc=%0d",
                         name, i, wx[i], wy[i], wc[i], wcyc[i], ex[i], ey[i], ecol, ecyc[i]);
            end
        end
        n_checks++;
        if (done_cyc != edone) begin
            n_fail++;
            $display("FAIL %s_done_cycle: got %0d want %0d", name, done_cyc, edone);
        end
    endtask

    task automatic test_reset;
        #2;
        n_checks++;
        if (we !== 0 || busy !== 0 || done !== 0 || color !== 0 || addr_x !== 0 || addr_y !== 0) begin
            n_fail++;
            $display("FAIL reset_outputs: we=%b busy=%b done=%b color=%0d x=%0d y=%0d want all 0",
                     we, busy, done, color, addr_x, addr_y);
        end
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_basic_fill;
        run_cmd(2, 3, 4, 4, 2, 0, -1, 50);
        expect_writes("basic", '{2, 3, 4, 2, 3, 4}, '{3, 3, 3, 4, 4, 4}, '{1, 2, 3, 4, 5, 6}, 2, 7);
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_ready_after: ready=%b busy=%b want 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_swapped;
        run_cmd(10, 5, 8, 5, 1, 0, -1, 50);
        expect_writes("swapped", '{8, 9, 10}, '{5, 5, 5}, '{1, 2, 3}, 1, 4);
    endtask

    task automatic test_clip;
        run_cmd(1278, 1023, 1300, 1030, 3, 0, -1, 50);
        expect_writes("clip", '{1278, 1279}, '{1023, 1023}, '{1, 2}, 3, 3);
        run_cmd(1400, 0, 1400, 0, 1, 0, -1, 50);
        expect_writes("offscreen", '{}, '{}, '{}, 1, 1);
    endtask

    task automatic test_pause;
        run_cmd(0, 0, 3, 0, 2, 2, 4, 50);
        expect_writes("pause", '{0, 1, 2, 3}, '{0, 0, 0, 0}, '{1, 5, 6, 7}, 2, 8);
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        cmd_x0 = 0; cmd_y0 = 0; cmd_x1 = 99; cmd_y1 = 99; cmd_color = 3; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        n_checks++;
        if (we !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midfill_active: we=%b busy=%b want 1 1", we, busy);
        end
        arstn = 1'b0;
        #1;
        n_checks++;
        if (we !== 0 || busy !== 0 || done !== 0 || color !== 0 || addr_x !== 0 || addr_y !== 0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: we=%b busy=%b done=%b color=%0d x=%0d y=%0d want all 0",
                     we, busy, done, color, addr_x, addr_y);
        end
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || we !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: ready=%b we=%b want 1 0", cmd_ready, we);
        end
        run_cmd(5, 6, 5, 6, 1, 0, -1, 50);
        expect_writes("single", '{5}, '{6}, '{1}, 1, 2);
    endtask

`ifdef VGA_RECT_OUTLINE_EN
    task automatic test_outline;
        cmd_outline = 1'b1;
        run_cmd(0, 0, 3, 2, 1, 0, -1, 50);
        cmd_outline = 1'b0;
        expect_writes("outline", '{0, 1, 2, 3, 0, 3, 0, 1, 2, 3}, '{0, 0, 0, 0, 1, 1, 2, 2, 2, 2},
                      '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10}, 1, 11);
    endtask
`endif

    initial begin
        test_reset();
        test_basic_fill();
        test_swapped();
        test_clip();
        test_pause();
        test_async_reset();
`ifdef VGA_RECT_OUTLINE_EN
        test_outline();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_rect_fill.md
Name: vga_rect_fill

Overview:
- Drawing engine upstream of the VGA top-level video buffer write port.
- Accepts rectangle-fill commands over a valid/ready handshake.
- Emits one buffer write per clock (colour, x, y, write strobe) in raster order until the rectangle is painted.
- Outputs connect directly to the buffer's color/addr_x/addr_y/we inputs.

Parameters:
- COORD_W, 11, width of every x/y coordinate.
- COLOR_W, 2, colour code width (BLACK=0, WHITE=1, BLUE=2, GREEN=3).
- MAX_X, 1280, horizontal clip limit; columns >= MAX_X are never written.
- MAX_Y, 1024, vertical clip limit; rows >= MAX_Y are never written.

Ports:
- clk_i  input  1  system clock.
- arstn_i  input  1  asynchronous active-low reset; one clock.
- cmd_valid_i  input  1  command valid.
- cmd_ready_o  output  1  engine can accept a command.
- cmd_x0_i  input  COORD_W  corner A x.
- cmd_y0_i  input  COORD_W  corner A y.
- cmd_x1_i  input  COORD_W  corner B x.
- cmd_y1_i  input  COORD_W  corner B y.
- cmd_color_i  input  COLOR_W  fill colour.
- pause_i  input  1  stall pixel emission.
- color_o  output  COLOR_W  write colour.
- addr_x_o  output  COORD_W  write column.
- addr_y_o  output  COORD_W  write row.
- we_o  output  1  write strobe.
- busy_o  output  1  command in progress.
- done_o  output  1  one-cycle pulse at command completion.

Behaviour:
- Reset (asynchronous, arstn_i low): FSM to IDLE. cmd_ready_o=1 once reset is released. we_o, busy_o, done_o, color_o, addr_x_o, addr_y_o all 0.
- Reset mid-command aborts the command immediately; no further writes; the command is not resumed.
- FSM states: IDLE, FILL, DONE.
- IDLE:
  - cmd_ready_o=1.
  - Handshake on cmd_valid_i & cmd_ready_o: latch the command.
  - Normalise corners: xl=min(x0,x1), xh=max(x0,x1); same for y.
  - Clip: xh=min(xh,MAX_X-1), yh=min(yh,MAX_Y-1).
  - If xl>=MAX_X or yl>=MAX_Y, go to DONE with no writes. Otherwise go to FILL.
- FILL:
  - cmd_ready_o=0, busy_o=1.
  - Outputs are registered. The first write (xl,yl) appears with we_o=1 in the cycle after the handshake (latency 1).
  - Raster order: x increments inner from xl to xh; on x==xh, x returns to xl and y increments.
  - After the write at (xh,yh), go to DONE.
  - pause_i high: we_o=0; addr/colour and position counters hold; no pixel is skipped or duplicated. On release, emission resumes with the held pixel.
  - Total writes = (xh-xl+1)*(yh-yl+1). Degenerate 1x1 gives exactly one write.
- DONE: one cycle. done_o=1, busy_o=1, we_o=0. Next state IDLE; cmd_ready_o=1 in the following cycle.
- Commands presented while busy are not accepted and must be held by the source.
- Counters must not wrap when xh/yh equal 2^COORD_W-1. Compare against the end value before incrementing.
- cmd_* inputs are ignored outside the handshake cycle.
- we_o is never high in IDLE or DONE.

Optional Feature:
- Macro VGA_RECT_OUTLINE_EN.
- Defined: adds input cmd_outline_i, latched at handshake. When 1, only border pixels are written: y==yl, y==yh, x==xl, x==xh (clipped bounds). Interior positions are skipped entirely: no write and no cycle spent. Each interior row costs exactly 2 write cycles (xl then xh); a 1-wide row costs 1. The port and logic are absent otherwise.
- Undefined: every command is a solid fill.

Test Plan:
- Reset then cmd (x0=2,y0=3,x1=4,y1=4,color=2) -> 6 writes: (2,3),(3,3),(4,3),(2,4),(3,4),(4,4) on consecutive cycles starting 1 cycle after handshake, color_o=2; done_o pulses 1 cycle after the last write; cmd_ready_o high the next cycle.
- Swapped corners x0=10,x1=8,y0=5,y1=5 -> writes (8,5),(9,5),(10,5) only.
- Clip: x0=1278,x1=1300,y0=1023,y1=1030 -> exactly (1278,1023),(1279,1023); cmd x0=1400 -> zero writes, done_o pulses.
- pause_i high for 3 cycles mid-fill of 4x1 at (0,0) -> we_o low for those 3 cycles, sequence still exactly (0,0)..(3,0), no duplicates.
- arstn_i low during 100x100 fill -> all outputs 0 asynchronously; after release, cmd_ready_o=1 and a new 1x1 command produces exactly one write.
- With VGA_RECT_OUTLINE_EN, outline 4x3 at (0,0) -> 10 writes, (1,1),(2,1) never written.
